// File: rtl/frame_uart_tx.sv
// Frame-buffer readback transmitter: sweeps RAM addresses 0..DEPTH-1 and sends each byte as 8N1 UART.
// Optional FRAME_TX_CHKSUM_EN appends a modulo-256 sum byte after the last pixel.
module frame_uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 40000
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int BW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [BW-1:0]     BAUD_LAST = BW'(BAUD_CNT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        BIT_LAST  = 4'd9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WAIT     = 3'd2,
    LOAD     = 3'd3,
    SEND     = 3'd4,
    LOAD_SUM = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [BW-1:0]     baud_r, baud_s;
  logic [3:0]        bit_r, bit_s;
  logic [9:0]        shift_r, shift_s;
  logic              rd_en_r, rd_en_s;
  logic              tx_r, tx_s;
  logic              busy_r, busy_s;
  logic              done_r;
  logic              fin_r, fin_s;
`ifdef FRAME_TX_CHKSUM_EN
  logic [7:0]        sum_r, sum_s;
  logic              sum_phase_r, sum_phase_s;
`endif

  // Next-state, counter and output logic; fin marks the frame end one cycle before done.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    busy_s  = busy_r;
    fin_s   = 1'b0;
`ifdef FRAME_TX_CHKSUM_EN
    sum_s       = sum_r;
    sum_phase_s = sum_phase_r;
`endif
    case (state_r)
      IDLE: begin
        // busy is still high during the fin cycle, so a start there is dropped too
        if (fin_r) begin
          busy_s = 1'b0;
        end else if (start && !busy_r && !done_r) begin
          state_s = READ;
          busy_s  = 1'b1;
          addr_s  = {ADDR_W{1'b0}};
`ifdef FRAME_TX_CHKSUM_EN
          sum_s       = 8'd0;
          sum_phase_s = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      READ: state_s = WAIT;
      WAIT: state_s = LOAD;
      LOAD: begin
        shift_s = {1'b1, rd_data, 1'b0};
        baud_s  = {BW{1'b0}};
        bit_s   = 4'd0;
        state_s = SEND;
`ifdef FRAME_TX_CHKSUM_EN
        sum_s = sum_r + rd_data;
`endif
      end
`ifdef FRAME_TX_CHKSUM_EN
      LOAD_SUM: begin
        shift_s     = {1'b1, sum_r, 1'b0};
        baud_s      = {BW{1'b0}};
        bit_s       = 4'd0;
        sum_phase_s = 1'b1;
        state_s     = SEND;
      end
`endif
      SEND: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = {BW{1'b0}};
          if (bit_r == BIT_LAST) begin
            bit_s = 4'd0;
`ifdef FRAME_TX_CHKSUM_EN
            if (sum_phase_r) begin
              state_s = IDLE;
              fin_s   = 1'b1;
            end else if (addr_r == ADDR_LAST) begin
              state_s = LOAD_SUM;
            end else begin
              addr_s  = addr_r + 1'b1;
              state_s = READ;
            end
`else
            if (addr_r == ADDR_LAST) begin
              state_s = IDLE;
              fin_s   = 1'b1;
            end else begin
              addr_s  = addr_r + 1'b1;
              state_s = READ;
            end
`endif
          end else begin
            bit_s   = bit_r + 4'd1;
            shift_s = {1'b1, shift_r[9:1]};
          end
        end else begin
          baud_s = baud_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
    rd_en_s = (state_s == READ);
    tx_s    = (state_r == SEND) ? shift_r[0] : 1'b1;
  end

  // State and registered-output update with asynchronous reset to idle line.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      baud_r  <= {BW{1'b0}};
      bit_r   <= 4'd0;
      shift_r <= 10'h3FF;
      rd_en_r <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fin_r   <= 1'b0;
`ifdef FRAME_TX_CHKSUM_EN
      sum_r       <= 8'd0;
      sum_phase_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      rd_en_r <= rd_en_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= fin_r;
      fin_r   <= fin_s;
`ifdef FRAME_TX_CHKSUM_EN
      sum_r       <= sum_s;
      sum_phase_r <= sum_phase_s;
`endif
    end
  end

  assign rd_en   = rd_en_r;
  assign rd_addr = addr_r;
  assign tx      = tx_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Directed bench for frame_uart_tx: BAUD_CNT=10, DEPTH=4, 1-cycle RAM model.
// Define FRAME_TX_CHKSUM_EN for the build with the trailing sum byte.
module tb_frame_uart_tx;

  localparam int P = 103;
`ifdef FRAME_TX_CHKSUM_EN
  localparam int NBYTES = 5;
  localparam int DONE_T = 514;
`else
  localparam int NBYTES = 4;
  localparam int DONE_T = 413;
`endif

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic        tx, busy, done;

  logic [7:0] ram [0:3];
  logic [7:0] exp_bytes [0:4];
  logic       tx_log   [0:2047];
  logic       done_log [0:2047];
  logic       busy_log [0:2047];
  int         rd_t[$];
  int         rd_a[$];
  int         total = 0;
  int         bad = 0;

  always #5 sclk = ~sclk;

  frame_uart_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100),
    .ADDR_W  (16),
    .DEPTH   (4)
  ) dut (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .start  (start),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  // RAM model with one cycle of read latency
  always @(posedge sclk) begin
    if (rd_en) rd_data <= ram[rd_addr[1:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start (sampled at edge N) and log outputs for len cycles; t=0 is the cycle after edge N.
  task automatic run(input int len, input int s_at);
    rd_t.delete();
    rd_a.delete();
    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge sclk);
      tx_log[i]   = tx;
      done_log[i] = done;
      busy_log[i] = busy;
      if (rd_en) begin
        rd_t.push_back(i);
        rd_a.push_back(int'(rd_addr));
      end
      start = (i == s_at);
    end
    start = 1'b0;
  endtask

  function automatic int byte_t(input int base, input int k);
    return (k < 4) ? base + 4 + k * P : base + 4 + 3 * P + 101;
  endfunction

  function automatic logic [7:0] decode(input int s);
    logic [7:0] d;
    for (int b = 0; b < 8; b++) d[b] = tx_log[s + 10 * (b + 1) + 5];
    return d;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (done_log[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic check_frame(input int base, input int rd_idx);
    for (int k = 0; k < NBYTES; k++) begin
      check_val($sformatf("byte%0d", k), decode(byte_t(base, k)), exp_bytes[k]);
      check_val($sformatf("startbit%0d", k), tx_log[byte_t(base, k) + 5], 1'b0);
      check_val($sformatf("stopbit%0d", k), tx_log[byte_t(base, k) + 95], 1'b1);
      check_val($sformatf("pregap%0d", k), tx_log[byte_t(base, k) - 1], 1'b1);
    end
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("rd_time%0d", j), rd_t[rd_idx + j], base + j * P);
      check_val($sformatf("rd_addr%0d", j), rd_a[rd_idx + j], j);
    end
    check_val("done_at", done_log[base + DONE_T], 1'b1);
    check_val("done_before", done_log[base + DONE_T - 1], 1'b0);
    check_val("done_after", done_log[base + DONE_T + 1], 1'b0);
    check_val("busy_before_done", busy_log[base + DONE_T - 1], 1'b1);
    check_val("busy_at_done", busy_log[base + DONE_T], 1'b0);
  endtask

  task automatic idle_check(input string tag);
    int chg = 0;
    repeat (100) begin
      @(negedge sclk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) chg++;
    end
    check_val(tag, chg, 0);
  endtask

  initial begin
    ram[0] = 8'hA5; ram[1] = 8'h00; ram[2] = 8'hFF; ram[3] = 8'h3C;
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'hFF;
    exp_bytes[3] = 8'h3C; exp_bytes[4] = 8'hE0;
    rst_n = 1'b0;
    start = 1'b0;

    // Reset state
    repeat (5) @(negedge sclk);
    check_val("rst_tx", tx, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_rd_en", rd_en, 1'b0);
    rst_n = 1'b1;
    idle_check("idle_after_reset");

    // Basic dump with exact bit and gap timing
    run(DONE_T + 17, -1);
    check_frame(0, 0);
    check_val("rd_count", rd_t.size(), 4);
    check_val("done_count", count_done(0, DONE_T + 16), 1);
    check_val("tx_before_first", tx_log[3], 1'b1);
    check_val("tx_first_edge", tx_log[4], 1'b0);
    check_val("start_bit_last", tx_log[13], 1'b0);
    check_val("bit0_first", tx_log[14], 1'b1);
    check_val("gap_first", tx_log[104], 1'b1);

    // Start while busy (during byte 2) is ignored
    run(DONE_T + 17, 210);
    check_frame(0, 0);
    check_val("busy_rd_count", rd_t.size(), 4);
    check_val("busy_done_count", count_done(0, DONE_T + 16), 1);

    // Start sampled in the done cycle is ignored
    run(DONE_T + 30, DONE_T);
    check_val("donecyc_rd_count", rd_t.size(), 4);
    check_val("donecyc_done_count", count_done(0, DONE_T + 29), 1);
    check_val("donecyc_busy", busy_log[DONE_T + 10], 1'b0);

    // Back-to-back: start on the cycle after done
    run(2 * DONE_T + 20, DONE_T + 1);
    check_frame(0, 0);
    check_frame(DONE_T + 2, 4);
    check_val("b2b_rd_count", rd_t.size(), 8);
    check_val("b2b_done_count", count_done(0, 2 * DONE_T + 19), 2);

    // Reset in the middle of byte 1 (data bits of 0x00 hold tx low)
    run(153, -1);
    check_val("mid_tx_low", tx_log[152], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_tx", tx, 1'b1);
    check_val("mid_rst_busy", busy, 1'b0);
    @(negedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
    idle_check("idle_after_mid_reset");
    run(DONE_T + 17, -1);
    check_frame(0, 0);
    check_val("restart_rd_count", rd_t.size(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
